// File: rtl/aes_key_expand_if.sv
// Key-schedule bus: cipher-key load request and round-key stream with valid/ready.
interface aes_key_expand_if;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned IDX_W = 4;

  logic [KEY_W-1:0] key_in;
  logic             key_load;
  logic [KEY_W-1:0] rk_out;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             busy;
  logic             done;

  modport master (
    output key_in, key_load, rk_ready,
    input  rk_out, rk_idx, rk_valid, busy, done
  );

  modport slave (
    input  key_in, key_load, rk_ready,
    output rk_out, rk_idx, rk_valid, busy, done
  );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: loads a cipher key and streams round keys 0..NR,
// one per accepted handshake, through a single shared SubWord/RotWord/Rcon step.
module aes_key_expand #(
  parameter int unsigned NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  aes_key_expand_if.slave  bus
);
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state, state_next;
  logic [KEY_W-1:0]    rk_q, rk_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [IDX_W-1:0]    idx_inc;
  logic                handshake;
  logic                last_key;
  logic [WORD_W-1:0]   rot_w3, t_word;
  logic [WORD_W-1:0]   n0, n1, n2, n3;
  logic [KEY_W-1:0]    next_key;

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  assign idx_inc   = idx_q + IDX_W'(1);
  assign handshake = valid_q & bus.rk_ready;
  assign last_key  = (idx_q == IDX_W'(NR));

  // One round of the schedule: S-box on the rotated last word, then a 4-deep XOR chain.
  assign rot_w3   = {rk_q[23:0], rk_q[31:24]};
  assign t_word   = sub_word(rot_w3) ^ {rcon(idx_inc), 24'h000000};
  assign n0       = rk_q[127:96] ^ t_word;
  assign n1       = rk_q[95:64]  ^ n0;
  assign n2       = rk_q[63:32]  ^ n1;
  assign n3       = rk_q[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.key_load) state_next = EMIT;
      EMIT:    if (handshake && last_key) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; key_load is only honoured in IDLE.
  always_comb begin
    rk_d    = rk_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.key_load) begin
          rk_d    = bus.key_in;
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (last_key) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rk_d  = next_key;
            idx_d = idx_inc;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.rk_out   = rk_q;
  assign bus.rk_idx   = idx_q;
  assign bus.rk_valid = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors plus random keys against a word-level
// key-expansion model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_expand;
  localparam int NR = 10;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  aes_key_expand_if bus ();

  aes_key_expand #(.NR(NR)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [NR+1];
  logic [127:0] cap    [NR+1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Classic FIPS-197 word-indexed expansion into exp_rk[0..NR].
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [4*(NR+1)];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]], sbox_m[temp[15:8]], sbox_m[temp[7:0]]};
        temp = temp ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a falling edge; key 0 is on the bus at the next falling edge.
  task automatic load(input logic [127:0] key);
    expand(key);
    bus.key_in   = key;
    bus.key_load = 1'b1;
    bus.rk_ready = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
  endtask

  // Consumes keys 0..NR; returns at the falling edge where done should be high.
  task automatic stream(input int stall_at, input int stall_len, input int inject_at,
                        input bit rand_bp, output int cycles);
    int  n = 0;
    int  left = stall_len;
    bit  injected = 1'b0;
    bit  stall;
    cycles = 0;
    while (n <= NR && cycles < BUDGET) begin
      check("rk_valid", 128'(bus.rk_valid), 128'(1));
      check("rk_idx",   128'(bus.rk_idx), 128'(n));
      check("rk_out",   bus.rk_out, exp_rk[n]);
      check("busy",     128'(bus.busy), 128'(1));
      check("done_low", 128'(bus.done), 128'(0));
      cap[n] = bus.rk_out;
      stall = (n == stall_at && left > 0) || (rand_bp && $urandom_range(3) == 0);
      if (n == stall_at && left > 0) left--;
      bus.rk_ready = !stall;
      if (n == inject_at && !injected) begin
        bus.key_load = 1'b1;
        bus.key_in   = {$urandom, $urandom, $urandom, $urandom};
        injected     = 1'b1;
      end else begin
        bus.key_load = 1'b0;
      end
      if (!stall) n++;
      cycles++;
      @(negedge clk);
    end
    bus.key_load = 1'b0;
    bus.rk_ready = 1'b1;
    check("stream_timeout", 128'(cycles < BUDGET), 128'(1));
  endtask

  task automatic check_done();
    check("done_pulse", 128'(bus.done), 128'(1));
    check("done_busy",  128'(bus.busy), 128'(0));
    check("done_valid", 128'(bus.rk_valid), 128'(0));
    check("rk_held",    bus.rk_out, exp_rk[NR]);
  endtask

  task automatic idle_after();
    @(negedge clk);
    check("done_once", 128'(bus.done), 128'(0));
    check("idle_busy", 128'(bus.busy), 128'(0));
  endtask

  initial begin
    int cyc;
    logic [127:0] k;
    bus.key_in   = '0;
    bus.key_load = 1'b0;
    bus.rk_ready = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("rst_rk_out",   bus.rk_out, 128'(0));
    check("rst_rk_idx",   128'(bus.rk_idx), 128'(0));
    check("rst_rk_valid", 128'(bus.rk_valid), 128'(0));
    check("rst_busy",     128'(bus.busy), 128'(0));
    check("rst_done",     128'(bus.done), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 vector, rk_ready held high
    load(128'h2b7e151628aed2a6abf7158809cf4f3c);
    stream(-1, 0, -1, 1'b0, cyc);
    check("fips_cycles", 128'(cyc), 128'(NR + 1));
    check("fips_idx1",  cap[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_idx10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_done();
    idle_after();

    // All-zero key
    load(128'h0);
    stream(-1, 0, -1, 1'b0, cyc);
    check("zero_idx1",  cap[1],  128'h62636363626363636263636362636363);
    check("zero_idx10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check_done();
    idle_after();

    // Three-cycle stall at idx 4
    load({$urandom, $urandom, $urandom, $urandom});
    stream(4, 3, -1, 1'b0, cyc);
    check("bp_cycles", 128'(cyc), 128'(NR + 4));
    check_done();
    idle_after();

    // key_load pulsed mid-schedule is ignored
    load({$urandom, $urandom, $urandom, $urandom});
    stream(-1, 0, 3, 1'b0, cyc);
    check_done();
    idle_after();

    // Asynchronous reset at idx 5
    load({$urandom, $urandom, $urandom, $urandom});
    repeat (5) @(negedge clk);
    check("pre_rst_idx", 128'(bus.rk_idx), 128'(5));
    check("pre_rst_rk",  bus.rk_out, exp_rk[5]);
    #2 rst = 1'b1;
    #1;
    check("arst_rk_out",   bus.rk_out, 128'(0));
    check("arst_rk_idx",   128'(bus.rk_idx), 128'(0));
    check("arst_rk_valid", 128'(bus.rk_valid), 128'(0));
    check("arst_busy",     128'(bus.busy), 128'(0));
    check("arst_done",     128'(bus.done), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load({$urandom, $urandom, $urandom, $urandom});
    stream(-1, 0, -1, 1'b1, cyc);
    check_done();
    idle_after();

    // Back-to-back schedules: new key_load in the done cycle
    load({$urandom, $urandom, $urandom, $urandom});
    stream(-1, 0, -1, 1'b0, cyc);
    check_done();
    load({$urandom, $urandom, $urandom, $urandom});
    stream(-1, 0, -1, 1'b0, cyc);
    check("chain_cycles", 128'(cyc), 128'(NR + 1));
    check_done();
    idle_after();

    // Random keys under random backpressure
    for (int t = 0; t < 3; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load(k);
      stream(-1, 0, -1, 1'b1, cyc);
      check_done();
      idle_after();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
